// File: rtl/alarm_controller_pkg.sv
// Shared definitions for the lights-on alarm controller.
//   state_t      : FSM state encoding (IDLE/WARN/ALARM/MUTED)
//   max_int      : elaboration-time helper for sizing the timer
//   cond_qual    : alarm-condition qualifier (lights on, a door open, ignition off)
package alarm_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WARN  = 2'd1,
        ST_ALARM = 2'd2,
        ST_MUTED = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Ignition on, every door closed or lights off all count as "no condition".
    function automatic logic cond_qual(input logic luz, input logic any_door, input logic ign);
        return luz & any_door & ~ign;
    endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Body-sensor / annunciator bundle for alarm_controller.
//   sLuz, sPrta, sIgn, sAck : sensor and driver inputs, synchronous to clk
//   sWarn, sAlr, sMuted     : chime / alarm / muted indicators (registered)
//   alarm_cnt               : saturating count of ALARM entries
//   dbg_state               : current FSM state, for observation only
// The bundle carries level signals only; there is no valid/ready handshake.
// Every input is sampled on each rising clk edge and every output is a
// registered Moore decode that changes one cycle after the sampling edge.
interface alarm_controller_if #(
    parameter int N_DOORS = 2,
    parameter int CNT_W   = 4
);
    import alarm_controller_pkg::*;

    logic               sLuz;
    logic [N_DOORS-1:0] sPrta;
    logic               sIgn;
    logic               sAck;
    logic               sWarn;
    logic               sAlr;
    logic               sMuted;
    logic [CNT_W-1:0]   alarm_cnt;
    state_t             dbg_state;

    // Sensor side: drives the inputs, observes the annunciators.
    modport master (
        output sLuz, sPrta, sIgn, sAck,
        input  sWarn, sAlr, sMuted, alarm_cnt, dbg_state
    );

    // Controller side.
    modport slave (
        input  sLuz, sPrta, sIgn, sAck,
        output sWarn, sAlr, sMuted, alarm_cnt, dbg_state
    );

endinterface

// File: rtl/alarm_controller_timer.sv
// Loadable down-counter used to time the WARN and ALARM phases.
//   clk, reset   : clock and synchronous active-high reset
//   load_i       : load load_val_i (takes priority over dec_i)
//   load_val_i   : value to load
//   dec_i        : decrement by one; ignored once the count is zero
//   zero_o       : count is zero
module alarm_controller_timer #(
    parameter int TMR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [TMR_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            // Never wrap below zero.
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alarm_controller.sv
// Lights-on alarm controller.
// Qualifies "lights on, any door open, ignition off", chimes for WARN_CYCLES,
// then sounds the alarm for ALARM_CYCLES before muting itself. The driver can
// mute early with sAck. A saturating counter records every ALARM entry.
//   clk    : clock, rising edge
//   reset  : synchronous, active-high; returns to IDLE and clears the counter
//   bus    : alarm_controller_if slave (sensors in, annunciators out)
module alarm_controller
    import alarm_controller_pkg::*;
#(
    parameter int N_DOORS      = 2,
    parameter int WARN_CYCLES  = 4,
    parameter int ALARM_CYCLES = 8,
    parameter int CNT_W        = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    alarm_controller_if.slave         bus
);

    localparam int TMR_W = $clog2(max_int(WARN_CYCLES, ALARM_CYCLES)) + 1;
    localparam logic [TMR_W-1:0] WARN_LOAD  = TMR_W'(WARN_CYCLES - 1);
    localparam logic [TMR_W-1:0] ALARM_LOAD = TMR_W'(ALARM_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    state_t           state_q;
    state_t           state_d;
    logic             warn_q;
    logic             alr_q;
    logic             muted_q;
    logic [CNT_W-1:0] cnt_q;

    logic             cond;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;
    logic             cnt_inc;

    assign cond = cond_qual(bus.sLuz, |bus.sPrta, bus.sIgn);

    alarm_controller_timer #(
        .TMR_W (TMR_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Next-state and timer control. In WARN and ALARM a dropped condition wins
    // over sAck, which wins over the timeout.
    always_comb begin
        state_d      = state_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        cnt_inc      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cond) begin
                    state_d      = ST_WARN;
                    tmr_load     = 1'b1;
                    tmr_load_val = WARN_LOAD;
                end
            end
            ST_WARN: begin
                if (!cond) begin
                    state_d = ST_IDLE;
                end else if (bus.sAck) begin
                    state_d = ST_MUTED;
                end else if (tmr_zero) begin
                    state_d      = ST_ALARM;
                    tmr_load     = 1'b1;
                    tmr_load_val = ALARM_LOAD;
                    cnt_inc      = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_ALARM: begin
                if (!cond) begin
                    state_d = ST_IDLE;
                end else if (bus.sAck || tmr_zero) begin
                    state_d = ST_MUTED;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_MUTED: begin
                // sAck is ignored here; only a cleared condition re-arms.
                if (!cond) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, registered output decode and event counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            warn_q  <= 1'b0;
            alr_q   <= 1'b0;
            muted_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            warn_q  <= (state_d == ST_WARN);
            alr_q   <= (state_d == ST_ALARM);
            muted_q <= (state_d == ST_MUTED);
            if (cnt_inc && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.sWarn     = warn_q;
    assign bus.sAlr      = alr_q;
    assign bus.sMuted    = muted_q;
    assign bus.alarm_cnt = cnt_q;
    assign bus.dbg_state = state_q;

endmodule
